// File: rtl/uart_sample_tx.sv
// uart_sample_tx: serializes accepted bytes as 8N1/8N2 UART frames through a one-word holding register
module uart_sample_tx #(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("uart_sample_tx: CLK_DIV must be in 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_sample_tx: STOP_BITS must be 1 or 2");
    end
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, hold_q, hold_d;
    logic full_q, full_d, tx_q, tx_d, done_q, done_d;
    logic accept, wrap, last_stop, load;
    always_comb begin
        accept    = in_valid && !full_q;
        wrap      = cnt_q == LAST;
        last_stop = state_q == STOP && wrap && idx_q == LAST_STOP;
        load      = full_q && (state_q == IDLE || last_stop);
        state_d   = state_q;
        cnt_d     = (wrap || state_q == IDLE) ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        hold_d    = accept ? in_data : hold_q;
        full_d    = accept || (full_q && !load);
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = hold_q;
        end else if (wrap) begin
            if (state_q == START) begin
                state_d = DATA;
                idx_d   = '0;
            end else if (state_q == DATA) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end else if (state_q == STOP) begin
                idx_d   = last_stop ? 3'd0 : idx_q + 3'd1;
                state_d = last_stop ? IDLE : STOP;
            end
        end
        tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        done_d = state_d == STOP && cnt_d == LAST && idx_d == LAST_STOP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
    assign in_ready   = !full_q;
    assign busy       = state_q != IDLE || full_q;
    assign tx         = tx_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_uart_sample_tx.sv
// tb_uart_sample_tx: directed steps with a byte scoreboard fed by a UART line decoder
module tb_uart_sample_tx;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] in_data, in_data2;
    logic in_valid, in_valid2;
    logic in_ready, tx, busy, frame_done;
    logic in_ready2, tx2, busy2, frame_done2;
    int errors = 0;
    int checks = 0;
    int frames = 0;
    logic [7:0] q[$];
    int ph;
    int slot;
    logic act = 1'b0;
    logic [7:0] sh;
    uart_sample_tx #(.CLK_DIV(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
    );
    uart_sample_tx #(.CLK_DIV(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        return i == 0 ? 1'b0 : i <= 8 ? b[i-1] : 1'b1;
    endfunction
    always @(negedge clk) begin
        if (rst) act = 1'b0;
        else begin
            if (!act && tx === 1'b0) begin
                act = 1'b1;
                ph = 0;
            end else if (act) ph++;
            if (act && ph % 4 == 2) begin
                slot = ph / 4;
                if (slot == 0) chk("start_bit", tx, 0);
                else if (slot <= 8) sh[slot-1] = tx;
                else begin
                    chk("stop_bit", tx, 1);
                    chk("sb_nonempty", q.size() != 0, 1);
                    if (q.size() != 0) chk("frame_data", sh, q.pop_front());
                    frames++;
                    act = 1'b0;
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
    initial begin
        int fr0;
        logic [7:0] e2;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_valid2 = 1'b0; in_data2 = 8'h00;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("rst_tx", tx, 1);
            chk("rst_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", in_ready, 1);
        // single byte 0xA5
        fr0 = frames;
        in_valid = 1'b1; in_data = 8'hA5; q.push_back(8'hA5);
        chk("a5_ready0", in_ready, 1);
        for (int c = 1; c <= 42; c++) begin
            step();
            if (c == 1) begin
                in_valid = 1'b0; in_data = 8'h00;
                chk("a5_ready1", in_ready, 0);
                chk("a5_busy1", busy, 1);
                chk("a5_tx1", tx, 1);
            end
            if (c == 2) chk("a5_ready2", in_ready, 1);
            if (c >= 2 && c <= 41) chk("a5_tx", tx, exp_bit(8'hA5, (c - 2) / 4));
            chk("a5_done", frame_done, c == 41);
        end
        chk("a5_busy42", busy, 0);
        chk("a5_frames", frames - fr0, 1);
        chk("a5_sb_empty", q.size(), 0);
        // back-to-back 0x00 then 0xFF
        fr0 = frames;
        in_valid = 1'b1; in_data = 8'h00; q.push_back(8'h00);
        step();
        in_data = 8'hFF;
        chk("bb_ready1", in_ready, 0);
        step();
        chk("bb_ready2", in_ready, 1);
        q.push_back(8'hFF);
        step();
        in_valid = 1'b0;
        for (int c = 3; c <= 82; c++) begin
            chk("bb_done", frame_done, c == 41 || c == 81);
            if (c <= 42) chk("bb_ready", in_ready, c == 42);
            if (c == 41) chk("bb_tx41", tx, 1);
            if (c == 42) chk("bb_tx42", tx, 0);
            if (c == 82) chk("bb_busy82", busy, 0);
            step();
        end
        chk("bb_frames", frames - fr0, 2);
        chk("bb_sb_empty", q.size(), 0);
        // backpressure with in_data churning
        begin
            int n_acc;
            logic acc;
            fr0 = frames; n_acc = 0;
            in_valid = 1'b1; in_data = 8'h11;
            for (int c = 0; c < 300 && !(n_acc == 2 && !busy); c++) begin
                acc = in_valid && in_ready;
                if (acc) q.push_back(in_data);
                step();
                if (acc) n_acc++;
                if (n_acc == 2) in_valid = 1'b0;
                in_data = 8'($urandom);
            end
            chk("bp_accepts", n_acc, 2);
            chk("bp_idle", busy, 0);
            chk("bp_frames", frames - fr0, 2);
            chk("bp_sb_empty", q.size(), 0);
        end
        // reset mid-frame
        in_valid = 1'b1; in_data = 8'h3C; q.push_back(8'h3C);
        step();
        in_data = 8'h99;
        step();
        chk("mr_ready2", in_ready, 1);
        q.push_back(8'h99);
        step();
        in_valid = 1'b0;
        for (int c = 3; c < 20; c++) step();
        chk("mr_busy20", busy, 1);
        rst = 1'b1;
        q.delete();
        fr0 = frames;
        step();
        chk("mr_tx21", tx, 1);
        chk("mr_ready21", in_ready, 1);
        chk("mr_busy21", busy, 0);
        chk("mr_done21", frame_done, 0);
        rst = 1'b0;
        for (int c = 22; c <= 60; c++) begin
            step();
            chk("mr_idle_tx", tx, 1);
            chk("mr_idle_done", frame_done, 0);
            chk("mr_idle_busy", busy, 0);
        end
        chk("mr_no_frame", frames - fr0, 0);
        in_valid = 1'b1; in_data = 8'hC3; q.push_back(8'hC3);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            step();
        end
        chk("mr_after_busy", busy, 0);
        chk("mr_after_frames", frames - fr0, 1);
        chk("mr_after_sb_empty", q.size(), 0);
        // CLK_DIV=2, STOP_BITS=2, byte 0x81
        e2 = 8'h81;
        chk("s2_idle_tx", tx2, 1);
        in_valid2 = 1'b1; in_data2 = e2;
        step();
        in_valid2 = 1'b0;
        for (int c = 2; c <= 24; c++) begin
            step();
            if (c <= 23) chk("s2_tx", tx2, ((c - 2) / 2 >= 9) ? 1'b1 : exp_bit(e2, (c - 2) / 2));
            chk("s2_done", frame_done2, c == 23);
        end
        chk("s2_busy24", busy2, 0);
        chk("s2_tx24", tx2, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_sample_tx.md
Name: uart_sample_tx

Overview:
Downstream consumer of the 8-bit free-running counter/sample stream. Serializes each accepted byte as a UART frame (8N1 by default) on a single output pin, so counter values can be watched on a host terminal. A one-word holding register decouples the producer from the shifter, which allows back-to-back frames with no idle gap.

Parameters:
CLK_DIV, 16, clk cycles per UART bit; legal range 2..65535; elaboration error outside this range.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
in_data  input  8  sample byte from the counter stage.
in_valid  input  1  producer has a byte on in_data.
in_ready  output  1  holding register empty; the byte is accepted when in_valid & in_ready.
tx  output  1  UART line; idles high; registered output.
busy  output  1  high while a frame is in flight or the holding register is full.
frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Values while rst is high and in the first cycle after: tx=1, in_ready=1, busy=0, frame_done=0, FSM=IDLE, baud counter=0, bit index=0, holding register empty.
- Holding register:
  - Written on accept; in_ready = !hold_full, driven directly from the flag register.
  - in_data is sampled only on the accept edge. Later changes are ignored.
  - While in_ready=0, in_valid is ignored and nothing is dropped silently; the producer must hold its data.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if hold_full, load the shifter from hold, clear hold_full, go to START, clear the baud counter.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shifter[0] (LSB first); shift right every CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles. In the final cycle, frame_done=1. Next state:
    - if hold_full: load the shifter, clear hold_full, go directly to START (no idle cycle);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1, width clog2(CLK_DIV). It wraps at the bit boundary and is cleared on every frame load.
- Latency:
  - Accept in cycle 0 (idle, hold empty) → hold full in cycle 1 → tx=0 from cycle 2.
  - in_ready is low in cycle 1 and high again from cycle 2.
- Frame length: (9+STOP_BITS)*CLK_DIV cycles, tx-low edge to end of stop.
- Simultaneous events:
  - The shifter draining hold and a new accept cannot coincide, because in_ready=0 whenever hold is full.
  - An accept in the same cycle as frame_done is legal only if hold was empty. The new byte then waits in IDLE and its start bit begins 2 cycles later.
- busy = (FSM != IDLE) | hold_full.
- Reset mid-frame: the frame is truncated. tx=1 in the next cycle and the held byte is discarded. No frame_done is pulsed.

Test Plan:
All scenarios use CLK_DIV=4 and STOP_BITS=1 (frame = 40 cycles) unless noted.
- Reset: hold rst=1 for 3 cycles with in_valid=1 → tx=1, in_ready=1, busy=0, frame_done=0 throughout. No accept occurs.
- Single byte 0xA5, accepted in cycle 0 → tx bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles, cycles 2..41. frame_done=1 only in cycle 41; busy falls in cycle 42.
- Back-to-back 0x00 then 0xFF, in_valid held high → second byte accepted in cycle 2, then in_ready=0 until cycle 42. The 0xFF start bit begins in cycle 42 with no high gap between frames. frame_done pulses in cycles 41 and 81.
- Backpressure: producer changes in_data each cycle while in_ready=0 → only the value present on the accept edge is transmitted. Exactly 2 frames are emitted for 2 handshakes.
- Reset mid-frame: rst=1 in cycle 20 while sending 0x3C with another byte held → tx=1 from cycle 21, in_ready=1, busy=0, no frame_done. A new byte accepted afterwards transmits correctly.
- STOP_BITS=2, CLK_DIV=2, byte 0x81 → frame occupies 22 cycles. Stop-high lasts 4 cycles and frame_done falls in the last of them.
